imm_gen_pipe: RTL and testbench

//  Registered, parametrised immediate-generation stage for the RISC-V pipeline (ID side).

---
 rtl/imm_gen_pipe_pkg.sv | 18 +
 rtl/imm_decode_core.sv | 64 ++++++
 rtl/imm_gen_pipe.sv | 72 +++++++
 tb/tb_imm_gen_pipe.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// imm_pkg: immediate formats, RV opcodes and pipeline FSM state for imm_gen_pipe
package imm_pkg;
  typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z} imm_fmt_e;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_e;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
endpackage

// File: rtl/imm_decode_core.sv
// imm_decode_core: combinational RISC-V immediate decode and extension to XLEN
module imm_decode_core
  import imm_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ENABLE_ZICSR = 1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);
  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction
  logic sh64;
  assign sh64 = (XLEN == 64) && (instr[6:0] == OPC_OPIMM);
  always_comb begin
    imm = '0;
    fmt = FMT_NONE;
    illegal = 1'b0;
    case (instr[6:0])
      OPC_LOAD, OPC_JALR: begin
        fmt = FMT_I;
        imm = sx({{20{instr[31]}}, instr[31:20]});
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        if (instr[6:0] == OPC_OPIMM32 && XLEN != 64) illegal = 1'b1;
        else if (instr[13:12] == 2'b01) begin
          fmt = FMT_SH;
          imm = XLEN'(instr[25:20] & {sh64, 5'h1f});
        end else begin
          fmt = FMT_I;
          imm = sx({{20{instr[31]}}, instr[31:20]});
        end
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = sx({{20{instr[31]}}, instr[31:25], instr[11:7]});
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = sx({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        imm = sx({instr[31:12], 12'b0});
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = sx({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
      end
      OPC_SYSTEM: begin
        if (ENABLE_ZICSR != 0 && instr[14]) begin
          fmt = FMT_Z;
          imm = XLEN'(instr[19:15]);
        end
      end
      OPC_OP, OPC_FENCE: ;
      OPC_OP32: illegal = (XLEN != 64);
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate-generation stage with 2-entry skid buffer and flush
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ENABLE_ZICSR = 1,
  parameter int PC_W         = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr
);
  localparam int EW = XLEN + 4 + PC_W + 32;
  logic [XLEN-1:0] dec_imm;
  imm_fmt_e dec_fmt;
  logic dec_illegal, accept, drain, in_ready_d, in_ready_q;
  logic [EW-1:0] dec_entry, main_d, main_q, skid_d, skid_q;
  state_e state_d, state_q;
  imm_decode_core #(.XLEN(XLEN), .ENABLE_ZICSR(ENABLE_ZICSR)) u_dec (
    .instr(in_instr),
    .imm(dec_imm),
    .fmt(dec_fmt),
    .illegal(dec_illegal)
  );
  assign dec_entry = {dec_imm, dec_fmt, dec_illegal, in_pc, in_instr};
  assign accept = in_valid & in_ready_q;
  assign drain = (state_q != ST_EMPTY) & out_ready;
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    case (state_q)
      ST_EMPTY: if (accept) begin main_d = dec_entry; state_d = ST_ONE; end
      ST_ONE: begin
        if (accept && drain) main_d = dec_entry;
        else if (accept) begin skid_d = dec_entry; state_d = ST_FULL; end
        else if (drain) state_d = ST_EMPTY;
      end
      ST_FULL: if (drain) begin main_d = skid_q; state_d = ST_ONE; end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
    in_ready_d = state_d != ST_FULL;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = state_q != ST_EMPTY;
  assign {out_imm, out_fmt, out_illegal, out_pc, out_instr} = main_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks of decode (XLEN 32 and 64) and skid/flush handshake
module tb_imm_gen_pipe;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic [31:0] in_instr = 0, in_pc = 0;
  logic in_ready, out_valid, out_illegal, in_ready64, out_valid64, out_illegal64;
  logic [31:0] out_imm, out_pc, out_instr, out_pc64, out_instr64;
  logic [63:0] out_imm64;
  logic [2:0] out_fmt, out_fmt64;
  int n_tot = 0, n_bad = 0;
  imm_gen_pipe #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_pc(out_pc),
    .out_instr(out_instr)
  );
  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_pc(out_pc64),
    .out_instr(out_instr64)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_chk(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] e32,
                          input logic [2:0] f32, input logic il32, input logic [63:0] e64,
                          input logic [2:0] f64, input logic il64);
    in_valid = 1;
    in_instr = ins;
    in_pc = pc;
    tick();
    in_valid = 0;
    chk("valid", out_valid, 1);
    chk("imm32", out_imm, e32);
    chk("fmt32", out_fmt, f32);
    chk("ill32", out_illegal, il32);
    chk("pc", out_pc, pc);
    chk("instr", out_instr, ins);
    chk("imm64", out_imm64, e64);
    chk("fmt64", out_fmt64, f64);
    chk("ill64", out_illegal64, il64);
    tick();
    chk("drained", out_valid, 0);
  endtask
  initial begin
    tick();
    tick();
    reset = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_imm", out_imm, 0);
    chk("rst_fmt", out_fmt, 0);
    // decode vectors, each pushed alone with out_ready=1
    push_chk(32'hFFF00093, 32'h100, 32'hFFFFFFFF, 1, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0);
    push_chk(32'hFE000EE3, 32'h104, 32'hFFFFFFFC, 4, 0, 64'hFFFFFFFFFFFFFFFC, 4, 0);
    push_chk(32'h008000EF, 32'h108, 32'h00000008, 6, 0, 64'h0000000000000008, 6, 0);
    push_chk(32'h123452B7, 32'h10C, 32'h12345000, 5, 0, 64'h0000000012345000, 5, 0);
    push_chk(32'h800002B7, 32'h110, 32'h80000000, 5, 0, 64'hFFFFFFFF80000000, 5, 0);
    push_chk(32'h4210D093, 32'h114, 32'h00000001, 2, 0, 64'h0000000000000021, 2, 0);
    push_chk(32'h00000000, 32'h118, 32'h00000000, 0, 1, 64'h0, 0, 1);
    push_chk(32'hFE20AC23, 32'h11C, 32'hFFFFFFF8, 3, 0, 64'hFFFFFFFFFFFFFFF8, 3, 0);
    push_chk(32'h300FD073, 32'h120, 32'h0000001F, 7, 0, 64'h000000000000001F, 7, 0);
    push_chk(32'h002081B3, 32'h124, 32'h00000000, 0, 0, 64'h0, 0, 0);
    push_chk(32'hFFF0809B, 32'h128, 32'h00000000, 0, 1, 64'hFFFFFFFFFFFFFFFF, 1, 0);
    // back-pressure: A, B fill the buffer, C must wait
    out_ready = 0;
    in_valid = 1;
    in_instr = 32'hFFF00093;
    tick();
    chk("bp_ready_a", in_ready, 1);
    chk("bp_out_a", out_instr, 32'hFFF00093);
    in_instr = 32'h008000EF;
    tick();
    chk("bp_full", in_ready, 0);
    in_instr = 32'h123452B7;
    tick();
    chk("bp_hold_v", out_valid, 1);
    chk("bp_hold_a", out_instr, 32'hFFF00093);
    chk("bp_hold_imm", out_imm, 32'hFFFFFFFF);
    chk("bp_still_full", in_ready, 0);
    out_ready = 1;
    tick();
    chk("bp_b", out_instr, 32'h008000EF);
    chk("bp_b_imm", out_imm, 32'h8);
    chk("bp_reopen", in_ready, 1);
    tick();
    in_valid = 0;
    chk("bp_c", out_instr, 32'h123452B7);
    chk("bp_c_v", out_valid, 1);
    tick();
    chk("bp_empty", out_valid, 0);
    // flush while full, with a new input offered
    out_ready = 0;
    in_valid = 1;
    in_instr = 32'hFFF00093;
    tick();
    in_instr = 32'h008000EF;
    tick();
    chk("fl_full", in_ready, 0);
    flush = 1;
    in_instr = 32'hFE000EE3;
    tick();
    flush = 0;
    in_valid = 0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    out_ready = 1;
    tick();
    chk("fl_no_ghost", out_valid, 0);
    // flush on an input offered to an empty stage drops it
    in_valid = 1;
    flush = 1;
    in_instr = 32'hFE000EE3;
    tick();
    flush = 0;
    in_valid = 0;
    chk("fl_drop_in", out_valid, 0);
    // reset mid-stream
    out_ready = 0;
    in_valid = 1;
    in_instr = 32'h800002B7;
    in_pc = 32'h200;
    tick();
    chk("mid_valid", out_valid, 1);
    reset = 1;
    tick();
    reset = 0;
    in_valid = 0;
    chk("mr_valid", out_valid, 0);
    chk("mr_ready", in_ready, 1);
    chk("mr_imm", out_imm, 0);
    chk("mr_fmt", out_fmt, 0);
    chk("mr_ill", out_illegal, 0);
    chk("mr_pc", out_pc, 0);
    chk("mr_instr", out_instr, 0);
    chk("mr_imm64", out_imm64, 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
